// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, FSM state type and radix-4 partial-product selection for multiplier8
package mult_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam int ITERS = 4;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic [OP_W+1:0] pp_select(input logic [1:0] pair, input logic [OP_W-1:0] a, input logic [OP_W+1:0] a3);
    return pair == 2'd0 ? '0 : pair == 2'd1 ? {2'b00, a} : pair == 2'd2 ? {1'b0, a, 1'b0} : a3;
  endfunction
endpackage

// File: rtl/radix4_pp_sel.sv
// radix4_pp_sel: picks 0/a/2a/3a for one multiplier bit pair (pair, a, a3 in; 10-bit pp out)
module radix4_pp_sel
  import mult_pkg::*;
(
  input  logic [1:0]      pair,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W+1:0] a3,
  output logic [OP_W+1:0] pp
);
  assign pp = pp_select(pair, a, a3);
endmodule

// File: rtl/multiplier8.sv
// multiplier8: sequential radix-4 8x8->16 unsigned multiplier (clk, reset, start, a, b in; p, ready out)
module multiplier8
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p,
  output logic              ready
);
  state_t state, state_n;
  logic [OP_W-1:0] a_r, a_n, b_r, b_n;
  logic [OP_W+1:0] a3_r, a3_n, pp;
  logic [PROD_W-1:0] acc, acc_n, p_n, sum;
  logic [1:0] iter, iter_n;
  logic ready_n;
  radix4_pp_sel u_sel (.pair(b_r[{iter, 1'b0} +: 2]), .a(a_r), .a3(a3_r), .pp(pp));
  assign sum = acc + ({{(PROD_W-OP_W-2){1'b0}}, pp} << {iter, 1'b0});
  always_comb begin
    state_n = state;
    a_n = a_r;
    b_n = b_r;
    a3_n = a3_r;
    acc_n = acc;
    iter_n = iter;
    p_n = p;
    ready_n = ready;
    if (state == IDLE) begin
      if (start) begin
        a_n = a;
        b_n = b;
        a3_n = {2'b00, a} + {1'b0, a, 1'b0};
        acc_n = '0;
        iter_n = '0;
        ready_n = 1'b0;
        state_n = BUSY;
      end
    end else begin
      acc_n = sum;
      iter_n = iter + 2'd1;
      if (iter == 2'(ITERS-1)) begin
        p_n = sum;
        ready_n = 1'b1;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      a3_r <= '0;
      acc <= '0;
      iter <= '0;
      p <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      a_r <= a_n;
      b_r <= b_n;
      a3_r <= a3_n;
      acc <= acc_n;
      iter <= iter_n;
      p <= p_n;
      ready <= ready_n;
    end
  end
endmodule

// File: tb/tb_multiplier8.sv
// tb_multiplier8: randomized self-checking bench for multiplier8 against a plain a*b model
module tb_multiplier8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [15:0] p;
  logic ready;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_p = '0;
  multiplier8 dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b), .p(p), .ready(ready));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit noisy);
    start = 1'b1;
    a = x;
    b = y;
    tick();
    check("ready_drop", 32'(ready), 0);
    check("p_hold_accept", 32'(p), 32'(exp_p));
    for (int i = 0; i < 3; i++) begin
      start = noisy ? 1'($urandom) : 1'b0;
      a = noisy ? 8'($urandom) : a;
      b = noisy ? 8'($urandom) : b;
      tick();
      check("ready_busy", 32'(ready), 0);
      check("p_hold_busy", 32'(p), 32'(exp_p));
    end
    start = 1'b0;
    tick();
    exp_p = 16'(int'(x) * int'(y));
    check("ready_done", 32'(ready), 1);
    check("p_done", 32'(p), 32'(exp_p));
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("reset_p", 32'(p), 0);
    check("reset_ready", 32'(ready), 0);
    do_op(8'd0, 8'd0, 1'b0);
    do_op(8'd255, 8'd255, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("idle_ready", 32'(ready), 1);
      check("idle_p", 32'(p), 32'hFE01);
    end
    do_op(8'd255, 8'd1, 1'b0);
    do_op(8'd1, 8'd255, 1'b0);
    do_op(8'h80, 8'h02, 1'b0);
    start = 1'b1;
    a = 8'd12;
    b = 8'd13;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_p = '0;
    check("abort_p", 32'(p), 0);
    check("abort_ready", 32'(ready), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_done", 32'(ready), 0);
      check("abort_p_zero", 32'(p), 0);
    end
    do_op(8'd12, 8'd13, 1'b0);
    check("after_abort", 32'(p), 156);
    start = 1'b1;
    a = 8'd3;
    b = 8'd5;
    tick();
    for (int i = 0; i < 3; i++) tick();
    a = 8'd7;
    b = 8'd9;
    tick();
    check("b2b_ready1", 32'(ready), 1);
    check("b2b_p1", 32'(p), 15);
    tick();
    check("b2b_accept", 32'(ready), 0);
    check("b2b_p_hold", 32'(p), 15);
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0;
    tick();
    check("b2b_ready2", 32'(ready), 1);
    check("b2b_p2", 32'(p), 63);
    exp_p = 16'd63;
    for (int i = 0; i < 1500; i++) do_op(8'($urandom), 8'($urandom), 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
